agc_gain_ctrl: RTL and testbench

// Automatic gain controller closing the loop around the audio gain stage: consumes the gain stage's
// 24-bit two's-complement output samples, measures windowed peak level, and produces the 20-bit
// Q7.13 gain word (0x02000 = 1.0) that feeds the gain stage's gain input. The gain stage ramps

---
 rtl/agc_gain_ctrl.sv | 171 +++++++++++++++++
 tb/tb_agc_gain_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_ctrl.sv
// Automatic gain controller: windowed peak detector driving a clamped Q7.13 gain word.
// Issues step changes only; the downstream gain stage does its own ramping.
module agc_gain_ctrl #(
    parameter int unsigned WINDOW    = 1024,
    parameter logic [23:0] TARGET    = 24'h400000,
    parameter logic [23:0] HYST      = 24'h080000,
    parameter logic [19:0] STEP_UP   = 20'd16,
    parameter logic [19:0] STEP_DN   = 20'd64,
    parameter logic [19:0] GAIN_MIN  = 20'h00400,
    parameter logic [19:0] GAIN_MAX  = 20'hFFFFF,
    parameter logic [19:0] GAIN_INIT = 20'h02000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [23:0] sample,
    output logic [19:0] gain,
    output logic        gain_valid,
    output logic [23:0] peak,
    output logic        clip,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDecide = 2'd2, StUpdate = 2'd3} state_e;
    typedef enum logic [1:0] {ActHold, ActAttack, ActRelease, ActHalve} act_e;

    localparam int unsigned   CW      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WINDOW - 1);
    localparam logic [23:0]   ThrHi   = TARGET + HYST;
    localparam logic [23:0]   ThrLo   = TARGET - HYST;

    state_e        state_q, state_d;
    act_e          act_q, act_d;
    logic [19:0]   gain_q, gain_d;
    logic          gv_q, gv_d;
    logic [23:0]   peak_q, peak_d;
    logic          clip_q, clip_d;
    logic [23:0]   acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          pend_q, pend_d;

    logic [23:0] mag, acc_max;
    logic        clip_det, win_close;
    logic [20:0] attack_w, release_w;
    logic [19:0] attack_g, release_g, halve_g;

    // Sample magnitude, clip detection and candidate gain values (21-bit to avoid wrap)
    always_comb begin
        if (!sample[23])               mag = sample;
        else if (sample == 24'h800000) mag = 24'h7FFFFF;
        else                           mag = -sample;
        clip_det  = sample_valid && (mag == 24'h7FFFFF);
        acc_max   = (mag > acc_q) ? mag : acc_q;
        win_close = sample_valid && (count_q == LastCnt);

        attack_w  = {1'b0, gain_q} - {1'b0, STEP_DN};
        attack_g  = (attack_w[20] || attack_w < {1'b0, GAIN_MIN}) ? GAIN_MIN : attack_w[19:0];
        release_w = {1'b0, gain_q} + {1'b0, STEP_UP};
        release_g = (release_w > {1'b0, GAIN_MAX}) ? GAIN_MAX : release_w[19:0];
        halve_g   = ((gain_q >> 1) < GAIN_MIN) ? GAIN_MIN : (gain_q >> 1);
    end

    // Next-state: FSM, measurement accumulator and gain register
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        gain_d  = gain_q;
        gv_d    = 1'b0;
        peak_d  = peak_q;
        clip_d  = 1'b0;
        acc_d   = acc_q;
        count_d = count_q;
        pend_d  = pend_q;

        if (!enable) begin
            state_d = StIdle;
            act_d   = ActHold;
            gain_d  = GAIN_INIT;
            acc_d   = '0;
            count_d = '0;
            pend_d  = 1'b0;
        end else begin
            // Measurement runs in every active state and never stalls
            if (state_q != StIdle) begin
                clip_d = clip_det;
                if (sample_valid) begin
                    if (win_close) begin
                        peak_d  = acc_max;
                        acc_d   = '0;
                        count_d = '0;
                    end else begin
                        acc_d   = acc_max;
                        count_d = count_q + CW'(1);
                    end
                end
            end

            unique case (state_q)
                StIdle: begin
                    state_d = StRun;
                    acc_d   = '0;
                    count_d = '0;
                end
                StRun: begin
                    // Clip (or a clip left over from UPDATE) overrides a window close
                    if (clip_det || pend_q) begin
                        state_d = StUpdate;
                        act_d   = ActHalve;
                        peak_d  = peak_q;
                        acc_d   = '0;
                        count_d = '0;
                        pend_d  = 1'b0;
                    end else if (win_close) begin
                        state_d = StDecide;
                    end
                end
                StDecide: begin
                    state_d = StUpdate;
                    if (clip_det)            act_d = ActHalve;
                    else if (peak_q > ThrHi) act_d = ActAttack;
                    else if (peak_q < ThrLo) act_d = ActRelease;
                    else                     act_d = ActHold;
                end
                StUpdate: begin
                    state_d = StRun;
                    gv_d    = (act_q != ActHold);
                    if (clip_det) pend_d = 1'b1;
                    unique case (act_q)
                        ActAttack:  gain_d = attack_g;
                        ActRelease: gain_d = release_g;
                        ActHalve:   gain_d = halve_g;
                        ActHold:    gain_d = gain_q;
                    endcase
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            act_q   <= ActHold;
            gain_q  <= GAIN_INIT;
            gv_q    <= 1'b0;
            peak_q  <= '0;
            clip_q  <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            gain_q  <= gain_d;
            gv_q    <= gv_d;
            peak_q  <= peak_d;
            clip_q  <= clip_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    assign gain       = gain_q;
    assign gain_valid = gv_q;
    assign peak       = peak_q;
    assign clip       = clip_q;
    assign state      = state_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed bench for agc_gain_ctrl with WINDOW=8; two extra instances start near the gain clamps.
module tb_agc_gain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, enable, sample_valid;
    logic [23:0] sample;

    logic [19:0] gain, gain_hi, gain_lo;
    logic        gv, gv_hi, gv_lo;
    logic [23:0] peak, peak_hi, peak_lo;
    logic        clip, clip_hi, clip_lo;
    logic [1:0]  state, state_hi, state_lo;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [23:0] Quiet = 24'h010000;

    always #5 clk = ~clk;

    agc_gain_ctrl #(.WINDOW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid), .sample(sample),
        .gain(gain), .gain_valid(gv), .peak(peak), .clip(clip), .state(state)
    );

    agc_gain_ctrl #(.WINDOW(8), .GAIN_INIT(20'hFFFF8)) u_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid), .sample(sample),
        .gain(gain_hi), .gain_valid(gv_hi), .peak(peak_hi), .clip(clip_hi), .state(state_hi)
    );

    agc_gain_ctrl #(.WINDOW(8), .GAIN_INIT(20'h00500)) u_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid), .sample(sample),
        .gain(gain_lo), .gain_valid(gv_lo), .peak(peak_lo), .clip(clip_lo), .state(state_lo)
    );

    // Advance one clock; outputs are read 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] s);
        sample_valid = 1'b1;
        sample       = s;
        step();
        sample_valid = 1'b0;
        sample       = '0;
    endtask

    // Drop enable for one cycle, then re-enable: gain back to GAIN_INIT, state RUN
    task automatic reenable();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
    endtask

    // Full window with one loud sample, then two edges so the gain write is visible
    task automatic window(input logic [23:0] big);
        for (int i = 0; i < 8; i++) send((i == 4) ? big : Quiet);
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'($urandom_range(0, 1));
            sample       = 24'($urandom);
            enable       = 1'($urandom_range(0, 1));
            step();
        end
        n_cmp++; if (gain !== 20'h02000) begin n_err++; $display("FAIL reset_gain got %h want 02000", gain); end
        n_cmp++; if (gv !== 1'b0) begin n_err++; $display("FAIL reset_gv got %b want 0", gv); end
        n_cmp++; if (peak !== 24'h0) begin n_err++; $display("FAIL reset_peak got %h want 0", peak); end
        n_cmp++; if (clip !== 1'b0) begin n_err++; $display("FAIL reset_clip got %b want 0", clip); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
        sample_valid = 1'b0;
        sample       = '0;
        enable       = 1'b0;
        rst_n        = 1'b1;
        step();
    endtask

    task automatic test_release();
        enable = 1'b1;
        step();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL rel_run got %0d want 1", state); end
        for (int i = 0; i < 7; i++) send((i % 2 == 0) ? 24'h100000 : 24'hF00000);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL rel_open got %0d want 1", state); end
        send(24'hF00000);
        n_cmp++; if (peak !== 24'h100000) begin n_err++; $display("FAIL rel_peak got %h want 100000", peak); end
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL rel_decide got %0d want 2", state); end
        step();
        n_cmp++; if (state !== 2'd3 || gv !== 1'b0) begin
            n_err++; $display("FAIL rel_update got st=%0d gv=%b want st=3 gv=0", state, gv); end
        step();
        n_cmp++; if (gain !== 20'h02010 || gv !== 1'b1) begin
            n_err++; $display("FAIL rel_gain got %h gv=%b want 02010 gv=1", gain, gv); end
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL rel_back got %0d want 1", state); end
        step();
        n_cmp++; if (gv !== 1'b0) begin n_err++; $display("FAIL rel_pulse got %b want 0", gv); end
    endtask

    task automatic test_attack_hold();
        logic seen;
        reenable();
        n_cmp++; if (gain !== 20'h02000) begin n_err++; $display("FAIL att_init got %h want 02000", gain); end
        for (int i = 0; i < 8; i++) send((i == 3) ? 24'h900000 : Quiet);
        n_cmp++; if (peak !== 24'h700000) begin n_err++; $display("FAIL att_peak got %h want 700000", peak); end
        step();
        step();
        n_cmp++; if (gain !== 20'h01FC0 || gv !== 1'b1) begin
            n_err++; $display("FAIL att_gain got %h gv=%b want 01fc0 gv=1", gain, gv); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send((i == 2) ? 24'h400000 : ((i == 6) ? 24'hC00000 : Quiet));
            seen |= gv;
        end
        n_cmp++; if (peak !== 24'h400000) begin n_err++; $display("FAIL hold_peak got %h want 400000", peak); end
        for (int i = 0; i < 3; i++) begin
            step();
            seen |= gv;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL hold_gv got %b want 0", seen); end
        n_cmp++; if (gain !== 20'h01FC0) begin n_err++; $display("FAIL hold_gain got %h want 01fc0", gain); end
    endtask

    task automatic test_clip();
        reenable();
        for (int i = 0; i < 3; i++) send(Quiet);
        send(24'h800001);
        n_cmp++; if (clip !== 1'b1 || state !== 2'd3) begin
            n_err++; $display("FAIL clip_det got clip=%b st=%0d want clip=1 st=3", clip, state); end
        step();
        n_cmp++; if (gain !== 20'h01000 || gv !== 1'b1 || clip !== 1'b0) begin
            n_err++; $display("FAIL clip_halve got %h gv=%b clip=%b want 01000 1 0", gain, gv, clip); end
        for (int i = 0; i < 7; i++) send(Quiet);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL clip_restart got %0d want 1", state); end
        send(Quiet);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL clip_close got %0d want 2", state); end
        step();
        step();
        n_cmp++; if (gain !== 20'h01010) begin n_err++; $display("FAIL clip_rel got %h want 01010", gain); end
        // Clip on the window-closing sample: halve only
        reenable();
        for (int i = 0; i < 7; i++) send(Quiet);
        send(24'h7FFFFF);
        n_cmp++; if (state !== 2'd3 || clip !== 1'b1) begin
            n_err++; $display("FAIL cclose_st got st=%0d clip=%b want st=3 clip=1", state, clip); end
        step();
        n_cmp++; if (gain !== 20'h01000 || gv !== 1'b1) begin
            n_err++; $display("FAIL cclose_gain got %h gv=%b want 01000 gv=1", gain, gv); end
        step();
        step();
        n_cmp++; if (state !== 2'd1 || gain !== 20'h01000 || gv !== 1'b0) begin
            n_err++; $display("FAIL cclose_only got st=%0d %h gv=%b want 1 01000 0", state, gain, gv); end
    endtask

    task automatic test_clamps();
        reenable();
        send(Quiet);
        send(Quiet);
        send(24'h800000);
        step();
        n_cmp++; if (gain_lo !== 20'h00400) begin n_err++; $display("FAIL lo_halve got %h want 00400", gain_lo); end
        n_cmp++; if (gain_hi !== 20'h7FFFC) begin n_err++; $display("FAIL hi_halve got %h want 7fffc", gain_hi); end
        window(24'h700000);
        n_cmp++; if (gain_lo !== 20'h00400 || gv_lo !== 1'b1) begin
            n_err++; $display("FAIL lo_attack got %h gv=%b want 00400 gv=1", gain_lo, gv_lo); end
        reenable();
        window(Quiet);
        n_cmp++; if (gain_hi !== 20'hFFFFF) begin n_err++; $display("FAIL hi_rel1 got %h want fffff", gain_hi); end
        window(Quiet);
        n_cmp++; if (gain_hi !== 20'hFFFFF) begin n_err++; $display("FAIL hi_rel2 got %h want fffff", gain_hi); end
    endtask

    task automatic test_enable_drop();
        reenable();
        for (int i = 0; i < 8; i++) send(Quiet);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL dis_decide got %0d want 2", state); end
        enable = 1'b0;
        step();
        n_cmp++; if (state !== 2'd0 || gv !== 1'b0 || gain !== 20'h02000) begin
            n_err++; $display("FAIL dis_idle got st=%0d gv=%b %h want 0 0 02000", state, gv, gain); end
        step();
        n_cmp++; if (gv !== 1'b0) begin n_err++; $display("FAIL dis_nogv got %b want 0", gv); end
        enable = 1'b1;
        step();
        for (int i = 0; i < 7; i++) send(Quiet);
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL dis_fresh got %0d want 1", state); end
        send(Quiet);
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL dis_close got %0d want 2", state); end
        step();
        step();
        n_cmp++; if (gain !== 20'h02010 || gv !== 1'b1) begin
            n_err++; $display("FAIL dis_gain got %h gv=%b want 02010 gv=1", gain, gv); end
    endtask

    task automatic test_back_to_back();
        reenable();
        for (int i = 0; i < 8; i++) send(Quiet);
        step();
        send(24'h800000);
        n_cmp++; if (gain !== 20'h02010 || gv !== 1'b1 || clip !== 1'b1) begin
            n_err++; $display("FAIL b2b_upd got %h gv=%b clip=%b want 02010 1 1", gain, gv, clip); end
        step();
        n_cmp++; if (state !== 2'd3 || gv !== 1'b0) begin
            n_err++; $display("FAIL b2b_pend got st=%0d gv=%b want 3 0", state, gv); end
        step();
        n_cmp++; if (gain !== 20'h01008 || gv !== 1'b1) begin
            n_err++; $display("FAIL b2b_halve got %h gv=%b want 01008 gv=1", gain, gv); end
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        test_reset();
        test_release();
        test_attack_hold();
        test_clip();
        test_clamps();
        test_enable_drop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
